// File: rtl/sha256_round_ctrl_pkg.sv
// sha256_round_ctrl_pkg: shared types and constants for the SHA-256 round sequencer
package sha256_round_ctrl_pkg;
  localparam int DEF_ROUNDS = 64;
  localparam int DEF_MSG_WORDS = 16;
  localparam int DEF_CNT_W = 6;
  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;
  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
endpackage

// File: rtl/sha256_round_ctrl_if.sv
// sha256_round_ctrl_if: block handshake, datapath controls and digest handshake of the round sequencer
interface sha256_round_ctrl_if
  import sha256_round_ctrl_pkg::*;
#(parameter int CNT_W = DEF_CNT_W);
  logic valid, ready, first, abort, init, iv_sel, round_en, w_expand;
  logic h_update, digest_valid, digest_ready, busy;
  logic [CNT_W-1:0] round_cnt, k_addr;
  logic [3:0] w_idx;
  modport master (
    output valid, first, abort, digest_ready,
    input ready, init, iv_sel, round_en, round_cnt, k_addr, w_idx, w_expand, h_update, digest_valid, busy
  );
  modport slave (
    input valid, first, abort, digest_ready,
    output ready, init, iv_sel, round_en, round_cnt, k_addr, w_idx, w_expand, h_update, digest_valid, busy
  );
endinterface

// File: rtl/sha256_round_ctrl_counter.sv
// sha256_round_ctrl_counter: round index counter with clear, enable and terminal-count flag
module sha256_round_ctrl_counter #(
  parameter int ROUNDS = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  assign tc = cnt == CNT_W'(ROUNDS - 1);
endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: steps the SHA-256 compression datapath through its rounds, one per clock
module sha256_round_ctrl
  import sha256_round_ctrl_pkg::*;
#(
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int MSG_WORDS = DEF_MSG_WORDS,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  sha256_round_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic tc, clear, en;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.valid ? INIT : IDLE;
      INIT:    state_nx = bus.abort ? IDLE : ROUND;
      ROUND:   state_nx = bus.abort ? IDLE : tc ? FINAL : ROUND;
      FINAL:   state_nx = bus.abort ? IDLE : DONE;
      DONE:    state_nx = bus.digest_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // counter holds at the last round through FINAL/DONE so it never wraps within a block
  assign clear = state_nx == IDLE || state_nx == INIT;
  assign en = state == ROUND && !tc;
  sha256_round_ctrl_counter #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .cnt(cnt), .tc(tc)
  );
  // outputs are registered from the next state so nothing combinational reaches the ports
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.init <= 1'b0;
      bus.round_en <= 1'b0;
      bus.h_update <= 1'b0;
      bus.digest_valid <= 1'b0;
      bus.iv_sel <= 1'b0;
    end else begin
      state <= state_nx;
      bus.ready <= state_nx == IDLE;
      bus.busy <= state_nx != IDLE;
      bus.init <= state_nx == INIT;
      bus.round_en <= state_nx == ROUND;
      bus.h_update <= state_nx == FINAL;
      bus.digest_valid <= state_nx == DONE;
      if (state == IDLE && bus.valid) bus.iv_sel <= bus.first;
    end
  assign bus.round_cnt = cnt;
  assign bus.k_addr = cnt;
  assign bus.w_idx = cnt[3:0];
  assign bus.w_expand = cnt >= CNT_W'(MSG_WORDS);
endmodule
